// File: rtl/control_pkg.sv
// Shared control encodings for the pipeline: writeback sources, memory
// access sizes (funct3) and the memory-stage state machine.
package control_pkg;

  // Writeback source select
  localparam logic [1:0] WB_FROM_ALU = 2'd0;
  localparam logic [1:0] WB_FROM_MEM = 2'd1;
  localparam logic [1:0] WB_FROM_PC4 = 2'd2;

  // Load/store size, encoded exactly as the instruction funct3 field
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  // Data-memory handshake states
  typedef enum logic [1:0] {
    MS_IDLE,
    MS_REQ,
    MS_RSP
  } mem_state_e;

  // Natural alignment: bytes anywhere, halves on even, words on 4-byte boundaries
  function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] addr);
    logic ok;
    case (size[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~addr[0];
      default: ok = (addr == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Moves the addressed byte/half of a raw memory word down to bit 0 and
// sign- or zero-extends it according to the load size.
module load_align
  import control_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  size_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  // Lane shift followed by width-dependent extension
  always_comb begin
    shifted = rdata_i >> {addr_i, 3'b000};
    data_o  = shifted;
    case (size_i)
      MEM_B:   data_o = {{24{shifted[7]}}, shifted[7:0]};
      MEM_H:   data_o = {{16{shifted[15]}}, shifted[15:0]};
      MEM_BU:  data_o = {24'd0, shifted[7:0]};
      MEM_HU:  data_o = {16'd0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage with the MEM/WB register. Drives the data
// memory handshake, stalls upstream while an access is outstanding, and
// abandons an access with a fault if the response never arrives.
module mem_stage
  import control_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_alu_result_i,
  input  logic [31:0] ex_store_data_i,
  input  logic [31:0] ex_pc_plus_4_i,
  input  logic        ex_mem_read_i,
  input  logic        ex_mem_write_i,
  input  logic [2:0]  ex_mem_size_i,
  input  logic [1:0]  ex_wb_sel_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_regwrite_i,
  output logic        dmem_req_valid_o,
  input  logic        dmem_req_ready_i,
  output logic        dmem_req_we_o,
  output logic [31:0] dmem_req_addr_o,
  output logic [31:0] dmem_req_wdata_o,
  output logic [3:0]  dmem_req_be_o,
  input  logic        dmem_rsp_valid_i,
  input  logic [31:0] dmem_rsp_rdata_i,
  output logic        mem_stall_o,
  output logic [31:0] memwb_mem_data_o,
  output logic [31:0] memwb_alu_result_o,
  output logic [31:0] memwb_pc_plus_4_o,
  output logic [1:0]  memwb_wb_sel_o,
  output logic [4:0]  memwb_rd_o,
  output logic        memwb_regwrite_o,
  output logic        mem_fault_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  mem_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        mem_op, aligned, access, misaligned, is_load;
  logic        req_valid, done, timeout, in_progress, stall;
  logic [31:0] load_data;

  logic [31:0] mem_data_q, mem_data_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] pc_plus_4_q, pc_plus_4_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwrite_q, regwrite_d;
  logic        fault_q, fault_d;

  // A simultaneous read+write is a store, so a load is read without write
  assign mem_op     = ex_valid_i & (ex_mem_read_i | ex_mem_write_i);
  assign aligned    = is_aligned(ex_mem_size_i, ex_alu_result_i[1:0]);
  assign access     = mem_op & aligned;
  assign misaligned = (state_q == MS_IDLE) & mem_op & ~aligned;
  assign is_load    = ex_mem_read_i & ~ex_mem_write_i;

  load_align u_load_align (
    .rdata_i (dmem_rsp_rdata_i),
    .addr_i  (ex_alu_result_i[1:0]),
    .size_i  (ex_mem_size_i),
    .data_o  (load_data)
  );

  // Handshake sequencing and response timeout counter
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_valid = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      MS_IDLE: begin
        if (access) begin
          req_valid = 1'b1;
          state_d   = dmem_req_ready_i ? MS_RSP : MS_REQ;
        end
      end
      MS_REQ: begin
        req_valid = 1'b1;
        if (dmem_req_ready_i) state_d = MS_RSP;
      end
      MS_RSP: begin
        if (dmem_rsp_valid_i) begin
          done    = 1'b1;
          state_d = MS_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = MS_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = MS_IDLE;
    endcase
  end

  assign in_progress = (state_q != MS_IDLE) | access;
  assign stall       = in_progress & ~done & ~timeout;

  // Request payload comes straight from EX/MEM, which upstream holds while stalled
  always_comb begin
    dmem_req_addr_o = {ex_alu_result_i[31:2], 2'b00};
    dmem_req_we_o   = ex_mem_write_i;
    unique case (ex_mem_size_i[1:0])
      2'b00: begin
        dmem_req_be_o    = 4'b0001 << ex_alu_result_i[1:0];
        dmem_req_wdata_o = {4{ex_store_data_i[7:0]}};
      end
      2'b01: begin
        dmem_req_be_o    = 4'b0011 << ex_alu_result_i[1:0];
        dmem_req_wdata_o = {2{ex_store_data_i[15:0]}};
      end
      default: begin
        dmem_req_be_o    = 4'b1111;
        dmem_req_wdata_o = ex_store_data_i;
      end
    endcase
  end

  assign dmem_req_valid_o = rst_n & req_valid;
  assign mem_stall_o      = rst_n & stall;

  // MEM/WB next value: a bubble while stalled, otherwise the EX/MEM slot
  always_comb begin
    mem_data_d   = '0;
    alu_result_d = '0;
    pc_plus_4_d  = '0;
    wb_sel_d     = WB_FROM_ALU;
    rd_d         = '0;
    regwrite_d   = 1'b0;
    fault_d      = 1'b0;
    if (!stall) begin
      alu_result_d = ex_alu_result_i;
      pc_plus_4_d  = ex_pc_plus_4_i;
      wb_sel_d     = ex_wb_sel_i;
      rd_d         = ex_rd_i;
      regwrite_d   = ex_valid_i & ex_regwrite_i & ~misaligned & ~timeout;
      fault_d      = misaligned | timeout;
      if (done && is_load) mem_data_d = load_data;
    end
  end

  // State, counter and MEM/WB registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= MS_IDLE;
      cnt_q        <= '0;
      mem_data_q   <= '0;
      alu_result_q <= '0;
      pc_plus_4_q  <= '0;
      wb_sel_q     <= WB_FROM_ALU;
      rd_q         <= '0;
      regwrite_q   <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_data_q   <= mem_data_d;
      alu_result_q <= alu_result_d;
      pc_plus_4_q  <= pc_plus_4_d;
      wb_sel_q     <= wb_sel_d;
      rd_q         <= rd_d;
      regwrite_q   <= regwrite_d;
      fault_q      <= fault_d;
    end
  end

  assign memwb_mem_data_o   = mem_data_q;
  assign memwb_alu_result_o = alu_result_q;
  assign memwb_pc_plus_4_o  = pc_plus_4_q;
  assign memwb_wb_sel_o     = wb_sel_q;
  assign memwb_rd_o         = rd_q;
  assign memwb_regwrite_o   = regwrite_q;
  assign mem_fault_o        = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, misalignment, timeout,
// back-to-back pipeline flow and reset during an outstanding access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exValid;
  logic [31:0] exAluResult, exStoreData, exPcPlus4;
  logic        exMemRead, exMemWrite;
  logic [2:0]  exMemSize;
  logic [1:0]  exWbSel;
  logic [4:0]  exRd;
  logic        exRegwrite;
  logic        reqValid, reqReady, reqWe;
  logic [31:0] reqAddr, reqWdata;
  logic [3:0]  reqBe;
  logic        rspValid;
  logic [31:0] rspRdata;
  logic        memStall;
  logic [31:0] wbMemData, wbAluResult, wbPcPlus4;
  logic [1:0]  wbSel;
  logic [4:0]  wbRd;
  logic        wbRegwrite, memFault;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage #(.MAX_WAIT(16)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ex_valid_i         (exValid),
    .ex_alu_result_i    (exAluResult),
    .ex_store_data_i    (exStoreData),
    .ex_pc_plus_4_i     (exPcPlus4),
    .ex_mem_read_i      (exMemRead),
    .ex_mem_write_i     (exMemWrite),
    .ex_mem_size_i      (exMemSize),
    .ex_wb_sel_i        (exWbSel),
    .ex_rd_i            (exRd),
    .ex_regwrite_i      (exRegwrite),
    .dmem_req_valid_o   (reqValid),
    .dmem_req_ready_i   (reqReady),
    .dmem_req_we_o      (reqWe),
    .dmem_req_addr_o    (reqAddr),
    .dmem_req_wdata_o   (reqWdata),
    .dmem_req_be_o      (reqBe),
    .dmem_rsp_valid_i   (rspValid),
    .dmem_rsp_rdata_i   (rspRdata),
    .mem_stall_o        (memStall),
    .memwb_mem_data_o   (wbMemData),
    .memwb_alu_result_o (wbAluResult),
    .memwb_pc_plus_4_o  (wbPcPlus4),
    .memwb_wb_sel_o     (wbSel),
    .memwb_rd_o         (wbRd),
    .memwb_regwrite_o   (wbRegwrite),
    .mem_fault_o        (memFault)
  );

  // Drive one EX/MEM slot; PC+4 is derived from rd so it is distinct per slot
  task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic [31:0] sdata,
                               input logic rd_en, input logic wr_en, input logic [2:0] size,
                               input logic [1:0] sel, input logic [4:0] rd, input logic rw);
    exValid     = valid;
    exAluResult = addr;
    exStoreData = sdata;
    exPcPlus4   = 32'h0000_4000 + {25'd0, rd, 2'b00};
    exMemRead   = rd_en;
    exMemWrite  = wr_en;
    exMemSize   = size;
    exWbSel     = sel;
    exRd        = rd;
    exRegwrite  = rw;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    reqReady = 1'b0;
    rspValid = 1'b0;
    rspRdata = '0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 2'd0, 5'd0, 1'b0);
    #2;
    checkOutput("rst_req_valid", {31'd0, reqValid}, 32'd0);
    checkOutput("rst_stall", {31'd0, memStall}, 32'd0);
    checkOutput("rst_regwrite", {31'd0, wbRegwrite}, 32'd0);
    checkOutput("rst_alu", wbAluResult, 32'd0);
    checkOutput("rst_fault", {31'd0, memFault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] LB sign-extended load");
    applyStimulus(1'b1, 32'h0000_0103, 32'h0, 1'b1, 1'b0, 3'b000, 2'd1, 5'd5, 1'b1);
    reqReady = 1'b1;
    #1;
    checkOutput("lb_req_valid", {31'd0, reqValid}, 32'd1);
    checkOutput("lb_req_we", {31'd0, reqWe}, 32'd0);
    checkOutput("lb_req_addr", reqAddr, 32'h0000_0100);
    checkOutput("lb_stall_c0", {31'd0, memStall}, 32'd1);
    tick();
    checkOutput("lb_bubble", {31'd0, wbRegwrite}, 32'd0);
    reqReady = 1'b0;
    rspValid = 1'b1;
    rspRdata = 32'h80AA_BBCC;
    #1;
    checkOutput("lb_stall_c1", {31'd0, memStall}, 32'd0);
    checkOutput("lb_req_dropped", {31'd0, reqValid}, 32'd0);
    tick();
    checkOutput("lb_data", wbMemData, 32'hFFFF_FF80);
    checkOutput("lb_regwrite", {31'd0, wbRegwrite}, 32'd1);
    checkOutput("lb_rd", {27'd0, wbRd}, 32'd5);
    checkOutput("lb_wbsel", {30'd0, wbSel}, 32'd1);
    checkOutput("lb_fault", {31'd0, memFault}, 32'd0);
    rspValid = 1'b0;

    $display("[TB] SH with ready held low");
    applyStimulus(1'b1, 32'h0000_0102, 32'hABCD_1234, 1'b0, 1'b1, 3'b001, 2'd0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      reqReady = (i == 3);
      #1;
      checkOutput("sh_req_valid", {31'd0, reqValid}, 32'd1);
      checkOutput("sh_req_we", {31'd0, reqWe}, 32'd1);
      checkOutput("sh_be", {28'd0, reqBe}, 32'h0000_000C);
      checkOutput("sh_wdata", reqWdata, 32'h1234_1234);
      checkOutput("sh_addr", reqAddr, 32'h0000_0100);
      checkOutput("sh_stall", {31'd0, memStall}, 32'd1);
      tick();
    end
    reqReady = 1'b0;
    rspValid = 1'b1;
    rspRdata = 32'h5555_5555;
    #1;
    checkOutput("sh_ack_req_valid", {31'd0, reqValid}, 32'd0);
    checkOutput("sh_ack_stall", {31'd0, memStall}, 32'd0);
    tick();
    checkOutput("sh_regwrite", {31'd0, wbRegwrite}, 32'd0);
    checkOutput("sh_data", wbMemData, 32'd0);
    checkOutput("sh_alu", wbAluResult, 32'h0000_0102);
    rspValid = 1'b0;

    $display("[TB] misaligned LW");
    applyStimulus(1'b1, 32'h0000_0101, 32'h0, 1'b1, 1'b0, 3'b010, 2'd1, 5'd6, 1'b1);
    reqReady = 1'b1;
    #1;
    checkOutput("mis_req_valid", {31'd0, reqValid}, 32'd0);
    checkOutput("mis_stall", {31'd0, memStall}, 32'd0);
    tick();
    checkOutput("mis_fault", {31'd0, memFault}, 32'd1);
    checkOutput("mis_regwrite", {31'd0, wbRegwrite}, 32'd0);
    applyStimulus(1'b1, 32'h0000_0055, 32'h0, 1'b0, 1'b0, 3'b000, 2'd0, 5'd7, 1'b1);
    tick();
    checkOutput("mis_fault_clear", {31'd0, memFault}, 32'd0);
    checkOutput("add_regwrite", {31'd0, wbRegwrite}, 32'd1);
    checkOutput("add_pc4", wbPcPlus4, 32'h0000_401C);

    $display("[TB] LW response timeout");
    applyStimulus(1'b1, 32'h0000_0200, 32'h0, 1'b1, 1'b0, 3'b010, 2'd1, 5'd8, 1'b1);
    reqReady = 1'b1;
    tick();
    reqReady = 1'b0;
    for (int i = 0; i < 15; i++) begin
      checkOutput("to_stall_wait", {31'd0, memStall}, 32'd1);
      tick();
    end
    checkOutput("to_stall_last", {31'd0, memStall}, 32'd0);
    tick();
    checkOutput("to_fault", {31'd0, memFault}, 32'd1);
    checkOutput("to_regwrite", {31'd0, wbRegwrite}, 32'd0);
    checkOutput("to_alu", wbAluResult, 32'h0000_0200);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 2'd0, 5'd0, 1'b0);
    rspValid = 1'b1;
    rspRdata = 32'h1234_5678;
    #1;
    checkOutput("late_rsp_stall", {31'd0, memStall}, 32'd0);
    tick();
    checkOutput("late_rsp_fault", {31'd0, memFault}, 32'd0);
    checkOutput("late_rsp_regwrite", {31'd0, wbRegwrite}, 32'd0);
    checkOutput("late_rsp_data", wbMemData, 32'd0);
    rspValid = 1'b0;

    $display("[TB] ADD, LHU, ADD back to back");
    applyStimulus(1'b1, 32'h0000_0011, 32'h0, 1'b0, 1'b0, 3'b000, 2'd0, 5'd1, 1'b1);
    #1;
    checkOutput("add1_stall", {31'd0, memStall}, 32'd0);
    tick();
    checkOutput("add1_rd", {27'd0, wbRd}, 32'd1);
    checkOutput("add1_regwrite", {31'd0, wbRegwrite}, 32'd1);
    applyStimulus(1'b1, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 3'b101, 2'd1, 5'd2, 1'b1);
    reqReady = 1'b1;
    #1;
    checkOutput("lhu_stall", {31'd0, memStall}, 32'd1);
    tick();
    checkOutput("lhu_bubble", {31'd0, wbRegwrite}, 32'd0);
    reqReady = 1'b0;
    rspValid = 1'b1;
    rspRdata = 32'hFFFF_8001;
    tick();
    checkOutput("lhu_data", wbMemData, 32'h0000_8001);
    checkOutput("lhu_rd", {27'd0, wbRd}, 32'd2);
    checkOutput("lhu_regwrite", {31'd0, wbRegwrite}, 32'd1);
    rspValid = 1'b0;
    applyStimulus(1'b1, 32'h0000_0033, 32'h0, 1'b0, 1'b0, 3'b000, 2'd0, 5'd3, 1'b1);
    tick();
    checkOutput("add2_rd", {27'd0, wbRd}, 32'd3);
    checkOutput("add2_alu", wbAluResult, 32'h0000_0033);
    checkOutput("add2_data", wbMemData, 32'd0);

    $display("[TB] read+write treated as SB, invalid slot");
    applyStimulus(1'b1, 32'h0000_0201, 32'h0000_007F, 1'b1, 1'b1, 3'b000, 2'd1, 5'd4, 1'b0);
    reqReady = 1'b1;
    #1;
    checkOutput("rw_we", {31'd0, reqWe}, 32'd1);
    checkOutput("rw_be", {28'd0, reqBe}, 32'h0000_0002);
    checkOutput("rw_wdata", reqWdata, 32'h7F7F_7F7F);
    tick();
    reqReady = 1'b0;
    rspValid = 1'b1;
    rspRdata = 32'hCAFE_F00D;
    tick();
    checkOutput("rw_data", wbMemData, 32'd0);
    rspValid = 1'b0;
    applyStimulus(1'b0, 32'h0000_0300, 32'h0, 1'b1, 1'b0, 3'b010, 2'd1, 5'd10, 1'b1);
    reqReady = 1'b1;
    #1;
    checkOutput("inv_req_valid", {31'd0, reqValid}, 32'd0);
    checkOutput("inv_stall", {31'd0, memStall}, 32'd0);
    tick();
    checkOutput("inv_regwrite", {31'd0, wbRegwrite}, 32'd0);

    $display("[TB] reset during RSP");
    applyStimulus(1'b1, 32'h0000_0300, 32'h0, 1'b1, 1'b0, 3'b010, 2'd1, 5'd11, 1'b1);
    reqReady = 1'b1;
    tick();
    reqReady = 1'b0;
    #1;
    checkOutput("rsp_stall_pre", {31'd0, memStall}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_req_valid", {31'd0, reqValid}, 32'd0);
    checkOutput("mid_rst_stall", {31'd0, memStall}, 32'd0);
    checkOutput("mid_rst_regwrite", {31'd0, wbRegwrite}, 32'd0);
    checkOutput("mid_rst_rd", {27'd0, wbRd}, 32'd0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 2'd0, 5'd0, 1'b0);
    rspValid = 1'b1;
    rspRdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_regwrite", {31'd0, wbRegwrite}, 32'd0);
    checkOutput("post_rst_data", wbMemData, 32'd0);
    checkOutput("post_rst_fault", {31'd0, memFault}, 32'd0);
    applyStimulus(1'b1, 32'h0000_0099, 32'h0, 1'b0, 1'b0, 3'b000, 2'd0, 5'd9, 1'b1);
    #1;
    checkOutput("post_rst_stall", {31'd0, memStall}, 32'd0);
    tick();
    checkOutput("post_rst_add_rd", {27'd0, wbRd}, 32'd9);
    checkOutput("post_rst_add_data", wbMemData, 32'd0);
    rspValid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
